// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Imported by rr_pick8 and rr_arbiter8.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotated-priority pick: first set request at or above ptr, wrapping 7->0.
// Purely combinational; any=0 means no request is set.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] pick,
   output logic [ID_W-1:0]  pick_id,
   output logic             any
);

   logic [ID_W-1:0] idx;

   // walk from ptr upward, modulo-8 index wrap, keep the first hit
   always_comb begin
      pick    = '0;
      pick_id = '0;
      any     = 1'b0;
      idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + ID_W'(i);
         if (!any && req[idx]) begin
            any       = 1'b1;
            pick_id   = idx;
            pick[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter: IDLE/BUSY FSM, rotating pointer, registered grant.
// Define ARB_TIMEOUT_EN to build the hold counter that revokes long grants.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             v,
   output logic             timeout
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("rr_arbiter8: TIMEOUT_CYCLES must be at least 1");
   end

   state_t           state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_d;
   logic [ID_W-1:0]  gnt_id_d;

   logic [N_REQ-1:0] pick;
   logic [ID_W-1:0]  pick_id;
   logic             any;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_d;
`endif

   rr_pick8 u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .pick    (pick),
      .pick_id (pick_id),
      .any     (any)
   );

   // next state: grant from IDLE, release or revoke from BUSY
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt;
      gnt_id_d = gnt_id;
`ifdef ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      to_d     = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (en && any) begin
               state_d  = BUSY;
               gnt_d    = pick;
               gnt_id_d = pick_id;
               ptr_d    = pick_id + ID_W'(1);
`ifdef ARB_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         BUSY: begin
            if (!req[gnt_id]) begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == LAST) begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               to_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
      endcase
   end

   // state, pointer and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt     <= '0;
         gnt_id  <= '0;
         v       <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt     <= gnt_d;
         gnt_id  <= gnt_id_d;
         v       <= |gnt_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // hold counter and one-cycle revocation pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         timeout <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         timeout <= to_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed plus random bench for rr_arbiter8 against a cycle model.
// Built with TIMEOUT_CYCLES=4; follows ARB_TIMEOUT_EN if defined.
module tb_rr_arbiter8;

   localparam int T = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       v;
   logic       timeout;

   int n_cmp;
   int n_bad;

   // reference model state
   bit m_busy;
   int m_id;
   int m_ptr;
   int m_held;
   bit m_to;

   rr_arbiter8 #(.TIMEOUT_CYCLES(T)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .v       (v),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 1'b0;
      m_id   = 0;
      m_ptr  = 0;
      m_held = 0;
      m_to   = 1'b0;
   endtask

   task automatic model_edge();
      bit found;
      int c;
      m_to  = 1'b0;
      found = 1'b0;
      if (!m_busy) begin
         if (en && req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               c = (m_ptr + k) % 8;
               if (!found && req[c]) begin
                  found = 1'b1;
                  m_id  = c;
               end
            end
            m_busy = 1'b1;
            m_ptr  = (m_id + 1) % 8;
            m_held = 1;
         end
      end else if (!req[m_id]) begin
         m_busy = 1'b0;
      end else if (TO_EN && m_held == T) begin
         m_busy = 1'b0;
         m_to   = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   task automatic check(input string tag);
      logic [7:0] eg;
      logic [2:0] ei;
      logic       ev;
      logic       et;
      eg = m_busy ? (8'h01 << m_id) : 8'h00;
      ei = m_busy ? 3'(m_id) : 3'd0;
      ev = m_busy;
      et = m_to;
      n_cmp++;
      assert (gnt === eg) else begin
         n_bad++;
         $error("FAIL %s gnt: got %h want %h", tag, gnt, eg);
      end
      n_cmp++;
      assert (gnt_id === ei) else begin
         n_bad++;
         $error("FAIL %s gnt_id: got %0d want %0d", tag, gnt_id, ei);
      end
      n_cmp++;
      assert (v === ev) else begin
         n_bad++;
         $error("FAIL %s v: got %b want %b", tag, v, ev);
      end
      n_cmp++;
      assert (timeout === et) else begin
         n_bad++;
         $error("FAIL %s timeout: got %b want %b", tag, timeout, et);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check(tag);
   endtask

   task automatic expect_id(input string tag, input logic [2:0] want);
      n_cmp++;
      assert (gnt_id === want) else begin
         n_bad++;
         $error("FAIL %s id: got %0d want %0d", tag, gnt_id, want);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      check(tag);
      @(posedge clk);
      #1;
      check(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      int id;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      model_reset();

      // reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset");
      rst_n = 1'b1;

      // single requester 0
      en  = 1'b1;
      req = 8'h01;
      tick("single0");
      expect_id("single0", 3'd0);
      req = 8'h00;
      tick("rel0");

      // all requesting, each drops for one cycle after its grant
      do_reset("rst2");
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick("rot_gnt");
         expect_id("rot_seq", 3'(k % 8));
         id  = m_id;
         req = 8'hFF & ~(8'h01 << id);
         tick("rot_gap");
         req = (k == 8) ? 8'h00 : 8'hFF;
      end
      tick("rot_end");

      // wrap from ptr 6
      req = 8'h20;
      tick("to_ptr6");
      req = 8'h00;
      tick("to_ptr6_rel");
      req = 8'h41;
      tick("wrap6");
      expect_id("wrap6", 3'd6);
      req = 8'h01;
      tick("wrap_rel");
      tick("wrap0");
      expect_id("wrap0", 3'd0);
      req = 8'h00;
      tick("wrap_end");

      // en low blocks the next grant only
      req = 8'h08;
      tick("en_g3");
      expect_id("en_g3", 3'd3);
      en = 1'b0;
      tick("en_hold");
      req = 8'h20;
      for (int k = 0; k < 4; k++) tick("en_block");
      en = 1'b1;
      tick("en_g5");
      expect_id("en_g5", 3'd5);
      req = 8'h00;
      tick("en_end");

      // long hold: revoked after T cycles only with the hold counter
      req = 8'h14;
      tick("hold_g2");
      expect_id("hold_g2", 3'd2);
      for (int k = 0; k < 3; k++) tick("hold");
      tick("hold_to");
`ifdef ARB_TIMEOUT_EN
      n_cmp++;
      assert (timeout === 1'b1) else begin
         n_bad++;
         $error("FAIL to_pulse: got %b want 1", timeout);
      end
`endif
      for (int k = 0; k < 3; k++) tick("hold_after");
      req = 8'h00;
      tick("hold_end");
      tick("hold_end2");

      // async reset mid-grant
      req = 8'h02;
      tick("mid_g");
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst");
      @(posedge clk);
      #1;
      check("mid_rst_hold");
      rst_n = 1'b1;
      req   = 8'h80;
      tick("post_rst");
      expect_id("post_rst", 3'd7);
      req = 8'h00;
      tick("post_rel");

      // random traffic
      for (int k = 0; k < 600; k++) begin
         en  = ($urandom_range(0, 3) != 0);
         req = 8'($urandom);
         if ($urandom_range(0, 1) == 0) req = req & 8'($urandom);
         if (m_busy && $urandom_range(0, 3) == 0)
            req[m_id] = 1'b0;
         if ($urandom_range(0, 99) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check("rnd_rst");
            #1;
            rst_n = 1'b1;
         end
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles one grant may be held (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port en  input  1  arbitration enable; gates new grants only.
REQ-005 SHALL have port req  input  8  request lines, bit i = requester i.
REQ-006 SHALL have port gnt  output  8  registered one-hot grant; all-zero when none.
REQ-007 SHALL have port gnt_id  output  3  binary index of granted requester; 0 when none.
REQ-008 SHALL have port v  output  1  grant valid; high exactly when gnt nonzero.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse on forced grant revocation.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 In IDLE with en=1 and req!=0, SHALL select the first set req bit searching upward from ptr, wrapping 7->0, and enter BUSY.
REQ-012 Grant latency SHALL be one cycle: req sampled at edge k -> gnt/gnt_id/v valid after edge k.
REQ-013 On each new grant, ptr SHALL load (winner+1) mod 8; ptr wraps 7->0.
REQ-014 In IDLE with en=0 or req==0, SHALL stay in IDLE with gnt=0, v=0, ptr unchanged.
REQ-015 In BUSY, grant SHALL persist unchanged while req[gnt_id]=1, regardless of other req bits or en.
REQ-016 In BUSY, when req[gnt_id]=0 at an edge, SHALL return to IDLE, gnt=0, v=0 after that edge.
REQ-017 SHALL insert exactly one IDLE cycle between consecutive grants (no back-to-back handover).
REQ-018 en deasserted in BUSY SHALL NOT revoke the current grant; it blocks the next one only.
REQ-019 gnt SHALL never have more than one bit set; v SHALL equal |gnt; gnt_id SHALL encode gnt.
REQ-020 timeout SHALL be 0 in every cycle except as defined in REQ-025.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=IDLE, ptr=0, gnt=0, gnt_id=0, v=0, timeout=0, hold counter=0.
REQ-022 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-023 After rst_n rises, first grant SHALL search from index 0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL enable a hold counter, cleared on each grant and incremented per BUSY cycle.
REQ-025 With ARB_TIMEOUT_EN, BUSY for TIMEOUT_CYCLES cycles SHALL force IDLE (gnt=0) and pulse timeout=1 for one cycle on the same edge.
REQ-026 After a timeout the revoked requester SHALL be arbitrated normally; ptr has already passed it.
REQ-027 Without ARB_TIMEOUT_EN, no counter SHALL be built; timeout SHALL be tied 0; grants are held indefinitely.

Structure
REQ-028 Shared package arb_pkg SHALL hold N_REQ=8, ID_W=3, and the state typedef (IDLE, BUSY).
REQ-029 Rotated priority search SHALL be a sub-module rr_pick8: inputs req[7:0] and ptr[2:0]; outputs one-hot pick[7:0], pick_id[2:0], any; purely combinational.
REQ-030 rr_arbiter8 SHALL contain the FSM, ptr, output registers and optional counter.

Verification
REQ-031 Reset, then en=1, req=8'b0000_0001 -> next edge gnt=8'h01, gnt_id=0, v=1, ptr=1.
REQ-032 req=8'hFF held, each grantee drops req one cycle after grant, then reasserts -> gnt_ids 0,1,2,...,7,0 with one v=0 cycle between each.
REQ-033 ptr=6, req=8'b0100_0001 -> gnt_id=6; after release -> gnt_id=0; ptr=7 then 1.
REQ-034 BUSY on id 3, en=0, release req[3] with req[5]=1 -> v=0 and stays 0 until en=1, then gnt_id=5.
REQ-035 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req[2] held -> v high 4 cycles, then gnt=0, timeout=1 for one cycle, next grant to another requester if requesting.
REQ-036 Assert rst_n=0 between edges while v=1 -> gnt=0, v=0 immediately; after release, req=8'h80 -> gnt_id=7.
